// File: rtl/snitch_pkg.sv
// -----------------------------------------------------------------------------
// snitch_pkg
//
// Shared types for the Snitch cluster performance-counter unit:
//   core_events_t    per-core event strobes, bit position = event index
//   event_sel_e      event selector stored in a counter's CFG register
//   perf_cnt_cfg_t   layout of the 32-bit CFG register
//   PerfCfg/PerfValueLo/PerfValueHi/PerfReserved  register-select codes
//   event_hit()      picks the selected strobe out of one core's events
// -----------------------------------------------------------------------------
package snitch_pkg;

  // Declared MSB first, so retired_acc lands on bit 0 and issue_fpu on bit 6.
  typedef struct packed {
    logic issue_fpu;
    logic issue_fpu_seq;
    logic issue_core_to_fpu;
    logic retired_instr;
    logic retired_load;
    logic retired_i;
    logic retired_acc;
  } core_events_t;

  typedef enum logic [2:0] {
    EvRetiredAcc     = 3'd0,
    EvRetiredI       = 3'd1,
    EvRetiredLoad    = 3'd2,
    EvRetiredInstr   = 3'd3,
    EvIssueCoreToFpu = 3'd4,
    EvIssueFpuSeq    = 3'd5,
    EvIssueFpu       = 3'd6,
    EvNone           = 3'd7
  } event_sel_e;

  typedef struct packed {
    logic [15:0] core_mask;
    logic [10:0] reserved;
    logic        overflow;
    event_sel_e  event_sel;
    logic        enable;
  } perf_cnt_cfg_t;

  localparam logic [1:0] PerfCfg      = 2'd0;
  localparam logic [1:0] PerfValueLo  = 2'd1;
  localparam logic [1:0] PerfValueHi  = 2'd2;
  localparam logic [1:0] PerfReserved = 2'd3;

  // EvNone indexes the padding zero bit, so it can never count.
  function automatic logic event_hit(input core_events_t ev, input event_sel_e sel);
    logic [7:0] bits;
    bits = {1'b0, ev};
    return bits[sel];
  endfunction

endpackage

// File: rtl/snitch_event_counter.sv
// -----------------------------------------------------------------------------
// snitch_event_counter
//
// One counter slice: CFG (enable, event select, core mask, sticky overflow),
// the CounterWidth-bit count, and the per-cycle popcount of masked strobes.
//
// Optional feature macro: SNITCH_EVENT_COUNTERS_SNAPSHOT_EN
//   defined   - a VALUE_LO read latches the upper count bits; VALUE_HI reads
//               return that snapshot (atomic LO-then-HI wide read).
//   undefined - VALUE_HI reads return the live upper bits.
//
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset
//   core_events_i    per-core event strobes
//   wr_en_i          accepted write addressed to this slice
//   rd_en_i          accepted read addressed to this slice
//   reg_sel_i        register select (CFG / VALUE_LO / VALUE_HI / reserved)
//   wdata_i          write data
//   rdata_o          current value of the selected register
// -----------------------------------------------------------------------------
module snitch_event_counter
  import snitch_pkg::*;
#(
  parameter int unsigned NrCores      = 8,
  parameter int unsigned CounterWidth = 48
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  core_events_t [NrCores-1:0] core_events_i,
  input  logic                       wr_en_i,
  input  logic                       rd_en_i,
  input  logic [1:0]                 reg_sel_i,
  input  logic [31:0]                wdata_i,
  output logic [31:0]                rdata_o
);

  localparam int unsigned HiWidth  = CounterWidth - 32;
  localparam int unsigned IncWidth = $clog2(NrCores + 1);
  localparam int unsigned SumWidth = CounterWidth + 1;

  logic                    enable_q, enable_d;
  event_sel_e              event_sel_q, event_sel_d;
  logic                    overflow_q, overflow_d;
  logic [NrCores-1:0]      mask_q, mask_d;
  logic [CounterWidth-1:0] cnt_q, cnt_d;

  perf_cnt_cfg_t           wcfg;
  perf_cnt_cfg_t           rd_cfg;
  logic [IncWidth-1:0]     inc;
  logic [SumWidth-1:0]     sum;
  logic                    carry;
  logic [31:0]             hi_rd;

  assign wcfg = perf_cnt_cfg_t'(wdata_i);

  // Number of masked cores strobing the selected event this cycle.
  // NOTE: every signal written in an always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    inc = '0;
    if (enable_q) begin
      for (int unsigned c = 0; c < NrCores; c++) begin
        if (mask_q[c] && event_hit(core_events_i[c], event_sel_q)) begin
          inc = inc + IncWidth'(1);
        end
      end
    end
  end

  assign sum   = {1'b0, cnt_q} + SumWidth'(inc);
  assign carry = sum[CounterWidth];

  always_comb begin
    enable_d    = enable_q;
    event_sel_d = event_sel_q;
    mask_d      = mask_q;
    cnt_d       = sum[CounterWidth-1:0];
    overflow_d  = overflow_q | carry;
    if (wr_en_i) begin
      case (reg_sel_i)
        PerfCfg: begin
          enable_d    = wcfg.enable;
          event_sel_d = wcfg.event_sel;
          mask_d      = wcfg.core_mask[NrCores-1:0];
          // A carry in the same cycle beats the write-one-to-clear.
          overflow_d  = carry | (overflow_q & ~wcfg.overflow);
        end
        // A value write drops this cycle's increment, so no carry either;
        // the other half keeps its pre-increment value.
        PerfValueLo: begin
          cnt_d      = {cnt_q[CounterWidth-1:32], wdata_i};
          overflow_d = overflow_q;
        end
        PerfValueHi: begin
          cnt_d      = {wdata_i[HiWidth-1:0], cnt_q[31:0]};
          overflow_d = overflow_q;
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      enable_q    <= 1'b0;
      event_sel_q <= EvRetiredAcc;
      mask_q      <= '0;
      overflow_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      enable_q    <= enable_d;
      event_sel_q <= event_sel_d;
      mask_q      <= mask_d;
      overflow_q  <= overflow_d;
      cnt_q       <= cnt_d;
    end
  end

`ifdef SNITCH_EVENT_COUNTERS_SNAPSHOT_EN
  logic [HiWidth-1:0] snap_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      snap_q <= '0;
    end else if (rd_en_i && (reg_sel_i == PerfValueLo)) begin
      snap_q <= cnt_q[CounterWidth-1:32];
    end
  end

  always_comb begin
    hi_rd = '0;
    hi_rd[HiWidth-1:0] = snap_q;
  end
`else
  logic unused_rd_en;
  assign unused_rd_en = rd_en_i;

  always_comb begin
    hi_rd = '0;
    hi_rd[HiWidth-1:0] = cnt_q[CounterWidth-1:32];
  end
`endif

  // Reserved CFG bits and core-mask bits beyond NrCores are not stored.
  logic unused_wcfg;
  assign unused_wcfg = ^wcfg;

  always_comb begin
    rd_cfg                       = '0;
    rd_cfg.enable                = enable_q;
    rd_cfg.event_sel             = event_sel_q;
    rd_cfg.overflow              = overflow_q;
    rd_cfg.core_mask[NrCores-1:0] = mask_q;
    case (reg_sel_i)
      PerfCfg:     rdata_o = rd_cfg;
      PerfValueLo: rdata_o = cnt_q[31:0];
      PerfValueHi: rdata_o = hi_rd;
      default:     rdata_o = '0;
    endcase
  end

endmodule

// File: rtl/snitch_event_counters.sv
// -----------------------------------------------------------------------------
// snitch_event_counters
//
// Cluster performance-counter unit. NrCounters slices each count the masked
// strobes of one selected core event; software accesses them through a
// single-outstanding 32-bit request/response port.
//
// Optional feature macro: SNITCH_EVENT_COUNTERS_SNAPSHOT_EN (see the slice).
//
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset
//   core_events_i    NrCores x core_events_t strobes
//   req_valid_i/req_ready_o            request handshake
//   req_addr_i       {counter index, register select[1:0]}
//   req_write_i      1 = write, 0 = read
//   req_wdata_i      write data
//   rsp_valid_o/rsp_ready_i            response handshake
//   rsp_data_o       read data (0 for writes and unmapped counters)
// -----------------------------------------------------------------------------
module snitch_event_counters
  import snitch_pkg::*;
#(
  parameter int unsigned NrCores      = 8,
  parameter int unsigned NrCounters   = 4,
  parameter int unsigned CounterWidth = 48
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  core_events_t [NrCores-1:0]         core_events_i,
  input  logic                               req_valid_i,
  output logic                               req_ready_o,
  input  logic [$clog2(NrCounters)+1:0]      req_addr_i,
  input  logic                               req_write_i,
  input  logic [31:0]                        req_wdata_i,
  output logic                               rsp_valid_o,
  input  logic                               rsp_ready_i,
  output logic [31:0]                        rsp_data_o
);

  logic                  rsp_valid_q, rsp_valid_d;
  logic [31:0]           rsp_data_q, rsp_data_d;
  logic                  accept;
  logic [31:0]           req_idx;
  logic [31:0]           rd_mux;
  logic [NrCounters-1:0] slice_wr;
  logic [NrCounters-1:0] slice_rd;
  logic [31:0]           slice_rdata [NrCounters];

  // One transaction in flight: no new accept while a response is pending.
  assign req_ready_o = ~rst_i & ~rsp_valid_q;
  assign accept      = req_valid_i & req_ready_o;
  // Counter index as a full word, so indices >= NrCounters match no slice.
  assign req_idx     = 32'(req_addr_i) >> 2;

  always_comb begin
    rd_mux   = '0;
    slice_wr = '0;
    slice_rd = '0;
    for (int unsigned i = 0; i < NrCounters; i++) begin
      if (req_idx == i) begin
        rd_mux      = slice_rdata[i];
        slice_wr[i] = accept & req_write_i;
        slice_rd[i] = accept & ~req_write_i;
      end
    end
  end

  for (genvar i = 0; i < NrCounters; i++) begin : gen_counter
    snitch_event_counter #(
      .NrCores      (NrCores),
      .CounterWidth (CounterWidth)
    ) i_counter (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .core_events_i (core_events_i),
      .wr_en_i       (slice_wr[i]),
      .rd_en_i       (slice_rd[i]),
      .reg_sel_i     (req_addr_i[1:0]),
      .wdata_i       (req_wdata_i),
      .rdata_o       (slice_rdata[i])
    );
  end

  // Read data is captured at accept, i.e. before this cycle's updates land.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = req_write_i ? 32'd0 : rd_mux;
    end else if (rsp_valid_q && rsp_ready_i) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;

endmodule

// File: tb/tb_snitch_event_counters.sv
module tb_snitch_event_counters;
  import snitch_pkg::*;

  localparam int NC = 8;
  localparam int NK = 4;
  localparam int CW = 48;
  localparam longint unsigned Mod = 64'd1 << CW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  core_events_t [NC-1:0] ev;
  core_events_t [NC-1:0] ev_idle;
  assign ev_idle = '0;

  // Main instance (default parameters).
  logic        req_valid, req_write, rsp_ready, req_ready, rsp_valid;
  logic [3:0]  req_addr;
  logic [31:0] req_wdata, rsp_data;

  // Second instance with NrCounters = 5, so index 7 is addressable.
  logic        req_valid2, req_write2, rsp_ready2, req_ready2, rsp_valid2;
  logic [4:0]  req_addr2;
  logic [31:0] req_wdata2, rsp_data2;

  snitch_event_counters #(.NrCores(NC), .NrCounters(NK), .CounterWidth(CW)) dut (
    .clk_i(clk), .rst_i(rst), .core_events_i(ev),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .req_write_i(req_write), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data)
  );

  snitch_event_counters #(.NrCores(NC), .NrCounters(5), .CounterWidth(CW)) dut2 (
    .clk_i(clk), .rst_i(rst), .core_events_i(ev_idle),
    .req_valid_i(req_valid2), .req_ready_o(req_ready2), .req_addr_i(req_addr2),
    .req_write_i(req_write2), .req_wdata_i(req_wdata2),
    .rsp_valid_o(rsp_valid2), .rsp_ready_i(rsp_ready2), .rsp_data_o(rsp_data2)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit ev_rand = 1'b0;
  bit pulse_once = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model of the main instance ----------------
  longint unsigned m_cnt  [NK];
  longint unsigned m_snap [NK];
  bit              m_en   [NK];
  int              m_sel  [NK];
  bit [7:0]        m_mask [NK];
  bit              m_ovf  [NK];
  bit              m_pending;
  logic [31:0]     m_rsp;

  function automatic logic [31:0] m_read(input int k, input int r);
    case (r)
      0: return {8'h00, m_mask[k], 11'h000, m_ovf[k], 3'(m_sel[k]), m_en[k]};
      1: return 32'(m_cnt[k]);
`ifdef SNITCH_EVENT_COUNTERS_SNAPSHOT_EN
      2: return 32'(m_snap[k]);
`else
      2: return 32'(m_cnt[k] >> 32);
`endif
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk) begin : model
    bit acc, wr, carry;
    int a_idx, a_reg, inc;
    longint unsigned sum;
    logic [6:0] bits;
    if (rst) begin
      for (int k = 0; k < NK; k++) begin
        m_cnt[k] = 0; m_snap[k] = 0; m_en[k] = 0;
        m_sel[k] = 0; m_mask[k] = 0; m_ovf[k] = 0;
      end
      m_pending = 0;
      m_rsp = 0;
    end else begin
      acc   = req_valid && !m_pending;
      a_idx = int'(req_addr) >> 2;
      a_reg = int'(req_addr) & 3;
      if (acc) begin
        m_rsp = req_write ? 32'd0 : m_read(a_idx, a_reg);
        if (!req_write && a_reg == 1) m_snap[a_idx] = m_cnt[a_idx] >> 32;
        m_pending = 1;
      end else if (m_pending && rsp_ready) begin
        m_pending = 0;
      end
      for (int k = 0; k < NK; k++) begin
        inc = 0;
        carry = 0;
        if (m_en[k] && m_sel[k] < 7)
          for (int c = 0; c < NC; c++) begin
            bits = ev[c];
            if (m_mask[k][c] && bits[m_sel[k]]) inc++;
          end
        wr = acc && req_write && a_idx == k;
        if (wr && a_reg == 1) begin
          m_cnt[k] = (m_cnt[k] & ~64'hFFFF_FFFF) | 64'(req_wdata);
        end else if (wr && a_reg == 2) begin
          m_cnt[k] = (m_cnt[k] & 64'hFFFF_FFFF) | ((64'(req_wdata) << 32) & (Mod - 1));
        end else begin
          sum = m_cnt[k] + longint'(inc);
          carry = sum >= Mod;
          m_cnt[k] = sum % Mod;
        end
        if (wr && a_reg == 0) begin
          m_en[k]   = req_wdata[0];
          m_sel[k]  = int'(req_wdata[3:1]);
          m_mask[k] = req_wdata[23:16];
          if (req_wdata[4]) m_ovf[k] = 0;
        end
        if (carry) m_ovf[k] = 1;
      end
    end
  end

  // One cycle: wait for the falling edge, compare the main instance against
  // the model, then refresh random strobes.
  task automatic tick();
    @(negedge clk);
    check("req_ready", req_ready, !rst && !m_pending);
    check("rsp_valid", rsp_valid, m_pending);
    if (m_pending) check("rsp_data", rsp_data, m_rsp);
    if (ev_rand)
      for (int c = 0; c < NC; c++) ev[c] = core_events_t'($urandom_range(0, 127));
  endtask

  task automatic xact(input bit d2, input int addr, input bit wr, input logic [31:0] wd,
                      input int hold, output logic [31:0] rd);
    int budget;
    logic rdy, vld;
    logic [31:0] dat;
    if (d2) begin
      req_valid2 = 1; req_addr2 = 5'(addr); req_write2 = wr; req_wdata2 = wd;
    end else begin
      req_valid = 1; req_addr = 4'(addr); req_write = wr; req_wdata = wd;
    end
    budget = 0;
    rdy = d2 ? req_ready2 : req_ready;
    while (!rdy) begin
      tick();
      budget++;
      if (budget > 20) begin
        check("req_ready_timeout", 0, 1);
        break;
      end
      rdy = d2 ? req_ready2 : req_ready;
    end
    tick();  // accept happened on this edge
    if (pulse_once) begin ev = '0; pulse_once = 0; end
    req_valid = 0;
    req_valid2 = 0;
    vld = d2 ? rsp_valid2 : rsp_valid;
    check("rsp_latency", vld, 1);
    rd = d2 ? rsp_data2 : rsp_data;
    for (int h = 0; h < hold; h++) begin
      tick();
      rdy = d2 ? req_ready2 : req_ready;
      dat = d2 ? rsp_data2 : rsp_data;
      vld = d2 ? rsp_valid2 : rsp_valid;
      check("hold_req_ready", rdy, 0);
      check("hold_rsp_valid", vld, 1);
      check("hold_rsp_data", dat, rd);
    end
    if (d2) rsp_ready2 = 1; else rsp_ready = 1;
    tick();
    rsp_ready = 0;
    rsp_ready2 = 0;
    vld = d2 ? rsp_valid2 : rsp_valid;
    check("rsp_released", vld, 0);
  endtask

  task automatic set_all_instr();
    ev = '0;
    for (int c = 0; c < NC; c++) ev[c].retired_instr = 1'b1;
  endtask

  initial begin
    logic [31:0] rd, wd;
    int addr;
    rst = 1;
    ev = '0;
    req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; rsp_ready = 0;
    req_valid2 = 0; req_write2 = 0; req_addr2 = 0; req_wdata2 = 0; rsp_ready2 = 0;
    repeat (3) tick();
    rst = 0;
    tick();
    check("reset_rsp_data", rsp_data, 0);

    // Reset state of counter 0.
    xact(0, 0, 0, 0, 0, rd); check("reset_cfg0", rd, 0);
    xact(0, 1, 0, 0, 0, rd); check("reset_lo0", rd, 0);

    // enable, event 3, mask 0xFF; 8 cores x 10 cycles.
    xact(0, 0, 1, 32'h00FF_0007, 0, rd); check("write_rsp_zero", rd, 0);
    set_all_instr();
    repeat (10) tick();
    ev = '0;
    xact(0, 1, 0, 0, 0, rd); check("count_80", rd, 80);

    // Wrap from all-ones with a single strobe.
    xact(0, 1, 1, 32'hFFFF_FFFF, 0, rd);
    xact(0, 2, 1, 32'h0000_FFFF, 0, rd);
    ev[0].retired_instr = 1'b1;
    tick();
    ev = '0;
    xact(0, 1, 0, 0, 0, rd); check("wrap_lo", rd, 0);
    xact(0, 2, 0, 0, 0, rd); check("wrap_hi", rd, 0);
    xact(0, 0, 0, 0, 0, rd); check("ovf_set", rd, 32'h00FF_0017);
    xact(0, 0, 1, 32'h00FF_0017, 0, rd);
    xact(0, 0, 0, 0, 0, rd); check("ovf_cleared", rd, 32'h00FF_0007);

    // Write wins over a coincident increment.
    set_all_instr();
    pulse_once = 1;
    xact(0, 1, 1, 32'd5, 0, rd);
    xact(0, 1, 0, 0, 0, rd); check("write_wins_lo", rd, 5);
    xact(0, 2, 0, 0, 0, rd); check("write_wins_hi", rd, 0);

    // Wide read across a carry into the upper half.
    xact(0, 1, 1, 32'hFFFF_FFFF, 0, rd);
    xact(0, 2, 1, 32'h0, 0, rd);
    xact(0, 1, 0, 0, 0, rd); check("snap_lo", rd, 32'hFFFF_FFFF);
    ev[0].retired_instr = 1'b1;
    tick();
    ev = '0;
    xact(0, 2, 0, 0, 0, rd);
`ifdef SNITCH_EVENT_COUNTERS_SNAPSHOT_EN
    check("snap_hi", rd, 0);
`else
    check("live_hi", rd, 1);
`endif
    xact(0, 1, 0, 0, 0, rd); check("after_carry_lo", rd, 0);

    // Unmapped counter index on the 5-counter instance.
    xact(1, 28, 1, 32'hFFFF_FFFF, 0, rd); check("idx7_write_rsp", rd, 0);
    xact(1, 28, 0, 0, 3, rd);             check("idx7_cfg", rd, 0);
    xact(1, 29, 0, 0, 0, rd);             check("idx7_lo", rd, 0);
    xact(1, 16, 0, 0, 0, rd);             check("idx4_cfg_untouched", rd, 0);
    xact(1, 12, 0, 0, 0, rd);             check("idx3_cfg_untouched", rd, 0);

    // Reset with a response pending.
    req_valid = 1; req_addr = 4'd1; req_write = 0;
    tick();
    req_valid = 0;
    check("pending_before_reset", rsp_valid, 1);
    rst = 1;
    tick();
    check("reset_drops_rsp", rsp_valid, 0);
    check("reset_ready_low", req_ready, 0);
    rst = 0;
    tick();
    xact(0, 0, 0, 0, 0, rd); check("post_reset_cfg0", rd, 0);
    xact(0, 1, 0, 0, 0, rd); check("post_reset_lo0", rd, 0);

    // Random traffic against the model.
    ev_rand = 1;
    for (int n = 0; n < 300; n++) begin
      addr = $urandom_range(0, 15);
      case ($urandom_range(0, 2))
        0: wd = $urandom;
        1: wd = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        default: wd = 32'h0000_FFFF;
      endcase
      xact(0, addr, 1'($urandom_range(0, 1)), wd, $urandom_range(0, 3), rd);
      if ($urandom_range(0, 3) == 0) tick();
    end
    ev_rand = 0;
    ev = '0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
